// File: rtl/vector_scalar_mul_pipe.sv
// vector_scalar_mul_pipe
//   Multiplies a signed fixed-point scalar by each lane of a LANES-wide
//   fixed-point vector through a valid/ready pipeline of STAGES registers.
//   Stage 0 registers the full-precision products. The floor shift,
//   clamp/wrap and overflow detection happen on the way out of stage 0.
//   Later stages carry the finished lane values.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational from out_ready)
//   scalar_op         signed scalar, WIDTH bits, FRAC fractional bits
//   vector_op         lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready output handshake
//   result            per-lane product, same packing as vector_op
//   overflow_lanes    per-lane overflow of the presented result
//   overflow          OR of overflow_lanes
//   clear_sticky      clears sticky_overflow (a simultaneous set wins)
//   sticky_overflow   set by any transferred result with overflow
module vector_scalar_mul_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int LANES    = 3,
  parameter int STAGES   = 2,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       scalar_op,
  input  logic [LANES*WIDTH-1:0] vector_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       overflow_lanes,
  output logic                   overflow,
  input  logic                   clear_sticky,
  output logic                   sticky_overflow
);

  localparam int PW = 2 * WIDTH;

  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      stage_rdy;
  logic [PW-1:0]          prod_d [LANES];
  logic [PW-1:0]          prod_q [LANES];
  logic signed [PW-1:0]   shf    [LANES];
  logic [LANES*WIDTH-1:0] fin_res;
  logic [LANES-1:0]       fin_ovf;
  logic [LANES*WIDTH-1:0] last_res;
  logic [LANES-1:0]       last_ovf;
  logic                   sticky_q;
  logic                   sticky_d;

  // A stage can take new data when it is empty or its occupant moves on.
  // Walking from the output back lets bubbles collapse under a stall.
  always_comb begin : rdy_chain
    logic        nxt;
    int unsigned k;
    stage_rdy = '0;
    nxt       = out_ready;
    k         = 0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      k            = STAGES - 1 - i;
      stage_rdy[k] = !valid_q[k] || nxt;
      nxt          = stage_rdy[k];
    end
  end

  assign in_ready = stage_rdy[0] && !reset;

  // Sign-extend both operands to 2*WIDTH; the low 2*WIDTH bits of the
  // product are then the exact signed product.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_d[l] = {{WIDTH{scalar_op[WIDTH-1]}}, scalar_op}
                * {{WIDTH{vector_op[l*WIDTH+WIDTH-1]}}, vector_op[l*WIDTH +: WIDTH]};
    end
  end

  // Floor shift, then the value fits in WIDTH bits only if the bits from
  // WIDTH-1 upward are a pure sign extension.
  always_comb begin
    fin_res = '0;
    fin_ovf = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      shf[l]     = $signed(prod_q[l]) >>> FRAC;
      fin_ovf[l] = !((&shf[l][PW-1:WIDTH-1]) || !(|shf[l][PW-1:WIDTH-1]));
      if (SATURATE != 0 && fin_ovf[l]) begin
        fin_res[l*WIDTH +: WIDTH] = shf[l][PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        fin_res[l*WIDTH +: WIDTH] = shf[l][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stage_rdy[0] && in_valid) begin
      prod_q <= prod_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      assign last_res = fin_res;
      assign last_ovf = fin_ovf;
    end else begin : g_multi
      logic [LANES*WIDTH-1:0] res_q [1:STAGES-1];
      logic [LANES-1:0]       ovf_q [1:STAGES-1];

      always_ff @(posedge clk) begin
        if (stage_rdy[1] && valid_q[0]) begin
          res_q[1] <= fin_res;
          ovf_q[1] <= fin_ovf;
        end
        for (int unsigned k = 2; k < STAGES; k++) begin
          if (stage_rdy[k] && valid_q[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end

      assign last_res = res_q[STAGES-1];
      assign last_ovf = ovf_q[STAGES-1];
    end
  endgenerate

  assign sticky_d = (sticky_q && !clear_sticky) || (out_valid && out_ready && overflow);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (stage_rdy[0]) begin
        valid_q[0] <= in_valid;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (stage_rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
        end
      end
      sticky_q <= sticky_d;
    end
  end

  // Data registers are not reset; gating with out_valid keeps the
  // outputs at zero whenever nothing is presented.
  assign out_valid       = valid_q[STAGES-1];
  assign result          = out_valid ? last_res : '0;
  assign overflow_lanes  = out_valid ? last_ovf : '0;
  assign overflow        = |overflow_lanes;
  assign sticky_overflow = sticky_q;

endmodule

// File: tb/tb_vector_scalar_mul_pipe.sv
module tb_vector_scalar_mul_pipe;
  localparam int W = 32;
  localparam int F = 16;
  localparam int L = 3;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_ready, clear_sticky;
  logic [31:0]   scalar_op;
  logic [95:0]   vector_op;
  logic          in_ready, out_valid, overflow, sticky_overflow;
  logic [95:0]   result;
  logic [2:0]    overflow_lanes;
  logic          in_ready_w, out_valid_w, overflow_w, sticky_w;
  logic [95:0]   result_w;
  logic [2:0]    overflow_lanes_w;

  vector_scalar_mul_pipe #(.WIDTH(W), .FRAC(F), .LANES(L), .STAGES(S), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .scalar_op(scalar_op), .vector_op(vector_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow_lanes(overflow_lanes),
    .overflow(overflow), .clear_sticky(clear_sticky), .sticky_overflow(sticky_overflow)
  );

  vector_scalar_mul_pipe #(.WIDTH(W), .FRAC(F), .LANES(L), .STAGES(S), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .scalar_op(scalar_op), .vector_op(vector_op), .out_valid(out_valid_w),
    .out_ready(out_ready), .result(result_w), .overflow_lanes(overflow_lanes_w),
    .overflow(overflow_w), .clear_sticky(clear_sticky), .sticky_overflow(sticky_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic chkv(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact product, floor by 2^16, clamp or keep low 32 bits.
  function automatic void model(input logic [31:0] sc, input logic [95:0] vec,
                                output logic [95:0] rs, output logic [95:0] rw,
                                output logic [2:0] ov);
    longint      p;
    longint      qq;
    logic [31:0] lane;
    rs = '0;
    rw = '0;
    ov = '0;
    for (int l = 0; l < 3; l++) begin
      lane  = vec[l*32 +: 32];
      p     = longint'($signed(sc)) * longint'($signed(lane));
      qq    = p >>> 16;
      ov[l] = (qq > 64'sd2147483647) || (qq < -64'sd2147483648);
      rw[l*32 +: 32] = qq[31:0];
      if (!ov[l]) rs[l*32 +: 32] = qq[31:0];
      else        rs[l*32 +: 32] = (qq > 0) ? 32'h7FFFFFFF : 32'h80000000;
    end
  endfunction

  typedef struct {
    int          acc;
    logic [31:0] sc;
    logic [95:0] vec;
  } item_t;

  item_t       mq[$];
  logic [95:0] log_s[$];
  logic [95:0] log_w[$];
  logic [2:0]  log_ov[$];
  logic        sticky_m = 1'b0;
  logic        sticky_nxt;
  logic        exp_rdy, front_vis;
  logic [95:0] m_rs, m_rw;
  logic [2:0]  m_ov;
  int          ecnt = 0;

  // Compare process: every cycle, mid-period, against the queue model.
  initial begin
    wait (reset === 1'b1);
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rdy   = !reset && ((mq.size() < S) || out_ready);
      front_vis = (mq.size() > 0) && (ecnt >= mq[0].acc + S);
      chk1("in_ready", in_ready, exp_rdy);
      chk1("in_ready_w", in_ready_w, exp_rdy);
      chk1("out_valid", out_valid, front_vis);
      chk1("out_valid_w", out_valid_w, front_vis);
      chk1("sticky", sticky_overflow, sticky_m);
      chk1("sticky_w", sticky_w, sticky_m);
      m_ov = '0;
      if (front_vis) begin
        model(mq[0].sc, mq[0].vec, m_rs, m_rw, m_ov);
        chkv("result_sat", result, m_rs);
        chkv("result_wrap", result_w, m_rw);
        chkv("ovf_lanes", 96'(overflow_lanes), 96'(m_ov));
        chkv("ovf_lanes_w", 96'(overflow_lanes_w), 96'(m_ov));
        chk1("overflow", overflow, |m_ov);
      end
      if (reset) begin
        mq.delete();
        sticky_nxt = 1'b0;
      end else begin
        sticky_nxt = sticky_m && !clear_sticky;
        if (front_vis && out_ready) begin
          sticky_nxt = sticky_nxt || (|m_ov);
          log_s.push_back(result);
          log_w.push_back(result_w);
          log_ov.push_back(overflow_lanes);
          void'(mq.pop_front());
        end
        if (in_valid && exp_rdy) mq.push_back('{ecnt, scalar_op, vector_op});
      end
      @(posedge clk);
      ecnt++;
      sticky_m = sticky_nxt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] s, input logic [95:0] v);
    int n;
    scalar_op = s;
    vector_op = v;
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("send_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] SC_SAT  = 32'h01000000;
  localparam logic [95:0] VEC_SAT = {32'h00000000, 32'hFF000000, 32'h01000000};

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0;
    scalar_op = '0; vector_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    chk1("post_rst_sticky", sticky_overflow, 1'b0);
    chkv("post_rst_result", result, 96'h0);
    @(posedge clk);
    #1;

    // Basic multiply and latency
    send(32'h00020000, {32'h00004000, 32'hFFFD0000, 32'h00018000});
    @(negedge clk);
    chk1("lat_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("lat_on_time", out_valid, 1'b1);
    @(posedge clk);
    #1;

    send(SC_SAT, VEC_SAT);
    send(32'h00008000, {32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    idle(6);
    @(negedge clk);
    chk1("sticky_set", sticky_overflow, 1'b1);
    @(posedge clk);
    #1;

    clear_sticky = 1'b1;
    idle(1);
    clear_sticky = 1'b0;
    @(negedge clk);
    chk1("sticky_cleared", sticky_overflow, 1'b0);
    @(posedge clk);
    #1;

    // Clear collides with an overflowing output transfer
    send(SC_SAT, VEC_SAT);
    idle(1);
    clear_sticky = 1'b1;
    @(negedge clk);
    chk1("collide_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 clear_sticky = 1'b0;
    @(negedge clk);
    chk1("sticky_collide", sticky_overflow, 1'b1);
    @(posedge clk);
    #1 clear_sticky = 1'b1;
    idle(1);
    clear_sticky = 1'b0;
    @(negedge clk);
    chk1("sticky_idle_clear", sticky_overflow, 1'b0);
    @(posedge clk);
    #1;
    send(SC_SAT, VEC_SAT);
    idle(4);

    // Backpressure: 10 back-to-back, out_ready low for cycles 3..7
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          out_ready = !(i >= 3 && i <= 7);
          if (i == 6) begin
            @(negedge clk);
            chk1("bp_full_in_ready", in_ready, 1'b0);
          end
          if (i == 8) begin
            @(negedge clk);
            chk1("bp_release_in_ready", in_ready, 1'b1);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 10; t++) begin
          logic [31:0] tt;
          tt = t;
          send(32'h00010000 + tt * 32'h00008000,
               {tt * 32'h00030000, 32'hFFFF0000 - tt * 32'h00001000, tt * 32'h00001234});
        end
      end
    join
    idle(6);

    // Reset with two items in flight
    out_ready = 1'b0;
    send(SC_SAT, VEC_SAT);
    send(32'h00020000, {32'h00004000, 32'hFFFD0000, 32'h00018000});
    reset = 1'b1;
    @(negedge clk);
    chk1("pre_rst_sticky", sticky_overflow, 1'b1);
    chk1("pre_rst_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_sticky", sticky_overflow, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(8);

    // Hand-computed expectations for the first transfers
    chki("out_count", log_s.size(), 15);
    chkv("basic_result", log_s[0], {32'h00008000, 32'hFFFA0000, 32'h00030000});
    chkv("basic_ovf", 96'(log_ov[0]), 96'h0);
    chkv("sat_result", log_s[1], {32'h00000000, 32'h80000000, 32'h7FFFFFFF});
    chkv("wrap_result", log_w[1], 96'h0);
    chkv("sat_ovf", 96'(log_ov[1]), 96'h3);
    chkv("floor_result", log_s[2], {32'h00000000, 32'h00000000, 32'hFFFFFFFF});
    chkv("floor_ovf", 96'(log_ov[2]), 96'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_scalar_mul_pipe.md
# vector_scalar_mul_pipe

Pipelined, parametrised successor to the combinational vector-by-scalar multiplier. It multiplies a signed fixed-point scalar by each lane of a LANES-wide fixed-point vector. Each lane can saturate or wrap, and per-lane and sticky overflow flags are provided. Operands flow through a valid/ready-handshaked pipeline of STAGES registers. The block sits in the vector_math datapath between the transform/lighting stages, where multiplier timing no longer closes combinationally.

## Interface
Parameters:
- WIDTH, 32, total fixed-point width in bits (signed two's complement)
- FRAC, 16, fractional bits; 0 < FRAC < WIDTH
- LANES, 3, vector lanes; lane 0 = x, 1 = y, 2 = z
- STAGES, 2, pipeline depth and latency in cycles; STAGES ≥ 1
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low WIDTH bits)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts input this cycle
- scalar_op  in  WIDTH  scalar multiplier
- vector_op  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  LANES*WIDTH  per-lane product, same packing as vector_op
- overflow_lanes  out  LANES  per-lane overflow flag for the current result
- overflow  out  1  OR of overflow_lanes
- clear_sticky  in  1  clears sticky_overflow
- sticky_overflow  out  1  set by any transferred result with overflow = 1

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Per lane: p = signed(scalar) * signed(lane), 2*WIDTH bits full precision.
- Shift: q = p >>> FRAC (arithmetic shift, i.e. floor; no rounding).
- Overflow per lane: q does not fit in signed WIDTH bits.
- Output per lane:
  - SATURATE=1 and overflow: 2^(WIDTH-1)-1 when q > 0, otherwise -2^(WIDTH-1).
  - SATURATE=0: q[WIDTH-1:0].
  - In both modes, overflow_lanes still reports the overflow.
- Pipeline: stage k holds a valid bit plus data.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. It is combinational from out_ready; this is the single permitted comb path.
  - Bubbles collapse: a stalled output does not block empty upstream stages from filling.
- Multiply placement: the multiply is registered in stage 0. Shift, clamp and flag generation may be split across later stages. Result bits must be independent of STAGES.
- Ordering: results leave in acceptance order; none are dropped or duplicated.
- Stability: while out_valid && !out_ready, result, overflow_lanes and overflow hold stable.
- Sticky flag update, per cycle: next = (sticky && !clear_sticky) || (out transfer && overflow). Set wins over clear in the same cycle.
- Reset: clears every stage valid bit and sticky_overflow. In-flight data is discarded, including on reset mid-stream. Data registers need no reset.

## Timing
- Reset values:
  - out_valid = 0, sticky_overflow = 0.
  - in_ready = 1 from the first cycle after reset deasserts. It is 0 during reset.
  - result, overflow_lanes and overflow are don't-care while out_valid = 0; implementation drives 0 after reset.
- Latency: an input accepted at edge N is presented with out_valid = 1 after edge N+STAGES, provided no stalls.
- Throughput: one vector per cycle when out_ready = 1.
- Full stall: with out_ready = 0, at most STAGES items are buffered, then in_ready = 0.
- Stall release: when out_ready rises, in_ready rises in the same cycle (no lost cycle).
- Simultaneous in/out transfer on a full pipeline is legal and keeps occupancy constant.

## Test plan
WIDTH=32, FRAC=16, LANES=3, STAGES=2 unless stated.
- Basic multiply (SATURATE=1):
  - scalar 0x00020000 (2.0), vector (0x00018000, 0xFFFD0000, 0x00004000) = (1.5, -3.0, 0.25)
  - required: result (0x00030000, 0xFFFA0000, 0x00008000), overflow = 0, out_valid exactly 2 cycles after acceptance.
- Saturation and sticky:
  - scalar 0x01000000 (256.0), vector (0x01000000, 0xFF000000, 0) = (256.0, -256.0, 0)
  - SATURATE=1: result (0x7FFFFFFF, 0x80000000, 0), overflow_lanes = 3'b011, sticky_overflow = 1 after the transfer.
  - SATURATE=0 build, same input: result lanes 0/1 = 0x00000000, same flags.
- Floor rounding:
  - scalar 0x00008000 (0.5), lane x = 0xFFFFFFFF (-2^-16), lane y = 0x00000001
  - required: x = 0xFFFFFFFF, y = 0x00000000, no overflow.
- Backpressure:
  - 10 back-to-back vectors, with out_ready held 0 for cycles 3–7
  - required: in_ready = 0 after 2 items are buffered, all 10 results emerge in order with no loss or duplication, and result stays stable while stalled.
- Sticky clear collision:
  - clear_sticky = 1 in the same cycle as an overflowing output transfer → sticky_overflow stays 1.
  - clear_sticky = 1 on a later idle cycle → sticky_overflow = 0.
- Reset mid-stream:
  - reset asserted for 1 cycle with 2 items in flight
  - required: out_valid = 0 the next cycle, sticky_overflow = 0, in_ready = 1 once reset is low, and no stale result ever appears.
